// File: rtl/sram_req_arbiter_if.sv
// SRAM-like request/response bundle (req/addr_ok/data_ok).
// Handshake: a transaction is accepted on the cycle where req and addr_ok are
// both high; while req is high and addr_ok low, the master holds req and all
// request fields stable. Responses return in order, one per data_ok pulse,
// with rdata valid only in that cycle.
interface sram_req_arbiter_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [3:0]  wstrb;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (
    output req, wr, size, addr, wstrb, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, addr, wstrb, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/sram_req_arbiter.sv
// sram_req_arbiter: shares one SRAM-like memory port between the IF-stage
// instruction requester and the MEM-stage data requester.
// A grant that was not accepted is locked (HOLD) until mem addr_ok.
// The owner of every accepted transaction is queued in an in-order ID FIFO
// so each mem data_ok is steered back to the requester that issued it.
// Optional feature macro: ARB_RR_EN (round-robin tie break; default is
// fixed priority with the data requester winning).
module sram_req_arbiter #(
  parameter int OST_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       resetn,
  sram_req_arbiter_if.slave          inst_if,
  sram_req_arbiter_if.slave          data_if,
  sram_req_arbiter_if.master         mem_if,
  output logic                       arb_err_o,
  output logic                       dbg_state_o,
  output logic                       dbg_hold_owner_o,
  output logic [$clog2(OST_DEPTH):0] dbg_count_o
);

  localparam int PW = $clog2(OST_DEPTH);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_HOLD = 1'b1;

  localparam logic OWN_INST = 1'b0;
  localparam logic OWN_DATA = 1'b1;

  logic [0:0]           state_q, state_d;
  logic                 hold_own_q, hold_own_d;
  logic [OST_DEPTH-1:0] fifo_q;
  logic [PW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [PW:0]          count_q;
  logic                 err_q;

  logic full, empty, pick, grant, mem_req, accept, pop, head;

  assign full  = (count_q == (PW+1)'(OST_DEPTH));
  assign empty = (count_q == '0);

`ifdef ARB_RR_EN
  logic rr_prio_q, rr_prio_d;

  // Round-robin choice in IDLE: on a tie the side not granted last wins
  always_comb begin
    if (inst_if.req && data_if.req) pick = rr_prio_q;
    else if (data_if.req)           pick = OWN_DATA;
    else                            pick = OWN_INST;
  end

  // After each accept, priority moves to the side that was not served
  always_comb begin
    rr_prio_d = rr_prio_q;
    if (accept) rr_prio_d = ~grant;
  end

  // Round-robin pointer register, starts favouring the data requester
  always_ff @(posedge clk) begin
    if (!resetn) rr_prio_q <= OWN_DATA;
    else         rr_prio_q <= rr_prio_d;
  end
`else
  // Fixed priority choice in IDLE: data requester beats instruction requester
  always_comb begin
    pick = data_if.req ? OWN_DATA : OWN_INST;
  end
`endif

  // Grant selection: a locked HOLD owner overrides the IDLE choice
  always_comb begin
    grant   = pick;
    mem_req = 1'b0;
    if (state_q == S_HOLD) begin
      grant   = hold_own_q;
      mem_req = 1'b1;
    end else if (!full && (inst_if.req || data_if.req)) begin
      mem_req = 1'b1;
    end
    if (!resetn) mem_req = 1'b0;
  end

  assign accept = mem_req & mem_if.addr_ok;
  assign head   = fifo_q[rd_ptr_q];
  assign pop    = resetn & mem_if.data_ok & ~empty;

  assign mem_if.req   = mem_req;
  assign mem_if.wr    = (grant == OWN_DATA) ? data_if.wr    : inst_if.wr;
  assign mem_if.size  = (grant == OWN_DATA) ? data_if.size  : inst_if.size;
  assign mem_if.addr  = (grant == OWN_DATA) ? data_if.addr  : inst_if.addr;
  assign mem_if.wstrb = (grant == OWN_DATA) ? data_if.wstrb : inst_if.wstrb;
  assign mem_if.wdata = (grant == OWN_DATA) ? data_if.wdata : inst_if.wdata;

  assign inst_if.addr_ok = accept & (grant == OWN_INST);
  assign data_if.addr_ok = accept & (grant == OWN_DATA);
  assign inst_if.data_ok = pop & (head == OWN_INST);
  assign data_if.data_ok = pop & (head == OWN_DATA);
  assign inst_if.rdata   = mem_if.rdata;
  assign data_if.rdata   = mem_if.rdata;

  assign arb_err_o        = err_q;
  assign dbg_state_o      = state_q;
  assign dbg_hold_owner_o = hold_own_q;
  assign dbg_count_o      = count_q;

  // Next-state logic: an unaccepted IDLE grant is locked until addr_ok
  always_comb begin
    state_d    = state_q;
    hold_own_d = hold_own_q;
    if (state_q == S_IDLE) begin
      if (mem_req && !accept) begin
        state_d    = S_HOLD;
        hold_own_d = grant;
      end
    end else if (accept) begin
      state_d = S_IDLE;
    end
  end

  // FSM, owner FIFO and sticky error register
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      hold_own_q <= OWN_DATA;
      fifo_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_own_q <= hold_own_d;
      if (accept) begin
        fifo_q[wr_ptr_q] <= grant;
        wr_ptr_q         <= wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({accept, pop})
        2'b10:   count_q <= count_q + (PW+1)'(1);
        2'b01:   count_q <= count_q - (PW+1)'(1);
        default: count_q <= count_q;
      endcase
      if (mem_if.data_ok && empty) err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Bench for sram_req_arbiter: a directed cycle table, hand-written
// multi-cycle sequences (tie break, grant lock, FIFO full, late response
// after reset) and a randomized run against a queue-based reference model.
module tb_sram_req_arbiter;
  localparam int D = 4;
`ifdef ARB_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif
  localparam bit INST = 1'b0;
  localparam bit DATA = 1'b1;

  logic              clk = 1'b0;
  logic              resetn;
  logic              arb_err;
  logic              dbg_state;
  logic              dbg_hold_owner;
  logic [$clog2(D):0] dbg_count;

  sram_req_arbiter_if inst_bus ();
  sram_req_arbiter_if data_bus ();
  sram_req_arbiter_if mem_bus ();

  sram_req_arbiter #(.OST_DEPTH(D)) dut (
    .clk              (clk),
    .resetn           (resetn),
    .inst_if          (inst_bus),
    .data_if          (data_bus),
    .mem_if           (mem_bus),
    .arb_err_o        (arb_err),
    .dbg_state_o      (dbg_state),
    .dbg_hold_owner_o (dbg_hold_owner),
    .dbg_count_o      (dbg_count)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int tests_run = 0;
  int failed    = 0;

  // ---------------- scoreboard ----------------
  task automatic check1(input string name, input logic act, input logic exp);
    tests_run++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0b expected %0b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit rstn, input bit ir, input bit dr, input bit aok, input bit dok);
    resetn           = rstn;
    inst_bus.req     = ir;
    data_bus.req     = dr;
    mem_bus.addr_ok  = aok;
    mem_bus.data_ok  = dok;
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    resetn = 1'b1;
  endtask

  task automatic fixed_fields();
    inst_bus.wr = 1'b0; inst_bus.size = 2'd2; inst_bus.addr = 32'h0000_1000;
    inst_bus.wstrb = 4'hf; inst_bus.wdata = 32'h0;
    data_bus.wr = 1'b1; data_bus.size = 2'd2; data_bus.addr = 32'h0000_2000;
    data_bus.wstrb = 4'h3; data_bus.wdata = 32'hdead_beef;
  endtask

  // ---------------- directed table ----------------
  typedef struct packed {
    logic rstn, ir, dr, aok, dok;
    logic mreq, sel, iaok, daok, idok, ddok, err;
  } vec_t;

  vec_t vecs [15];

  // ---------------- reference model state ----------------
  logic [0:0] exp_q [$];
  int  m_lock;
  bit  m_pref, m_err, m_mreq, m_g, m_acc, m_pop, m_head, ipend, dpend, rst_now;
  int  n;

  task automatic model_clear();
    exp_q.delete();
    m_lock = -1;
    m_pref = DATA;
    m_err  = 1'b0;
  endtask

  initial begin
    //             rdadk  m s i d i d e
    vecs[0]  = 12'b01111_0_0_0_0_0_0_0;
    vecs[1]  = 12'b11010_1_0_1_0_0_0_0;
    vecs[2]  = 12'b11010_1_0_1_0_0_0_0;
    vecs[3]  = 12'b10001_0_0_0_0_1_0_0;
    vecs[4]  = 12'b10001_0_0_0_0_1_0_0;
    vecs[5]  = 12'b10100_1_1_0_0_0_0_0;
    vecs[6]  = 12'b11100_1_1_0_0_0_0_0;
    vecs[7]  = 12'b11110_1_1_0_1_0_0_0;
    vecs[8]  = 12'b11011_1_0_1_0_0_1_0;
    vecs[9]  = 12'b10000_0_0_0_0_0_0_0;
    vecs[10] = 12'b10001_0_0_0_0_1_0_0;
    vecs[11] = 12'b10001_0_0_0_0_0_0_0;
    vecs[12] = 12'b10000_0_0_0_0_0_0_1;
    vecs[13] = 12'b00000_0_0_0_0_0_0_1;
    vecs[14] = 12'b10000_0_0_0_0_0_0_0;

    fixed_fields();
    mem_bus.rdata = 32'h0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();

    for (int i = 0; i < 15; i++) begin
      mem_bus.rdata = 32'ha500_0000 + 32'(i);
      drive(vecs[i].rstn, vecs[i].ir, vecs[i].dr, vecs[i].aok, vecs[i].dok);
      check1("tbl_mem_req", mem_bus.req, vecs[i].mreq);
      if (vecs[i].mreq) begin
        check32("tbl_mem_addr", mem_bus.addr, vecs[i].sel ? 32'h0000_2000 : 32'h0000_1000);
        check1("tbl_mem_wr", mem_bus.wr, vecs[i].sel);
      end
      check1("tbl_inst_addr_ok", inst_bus.addr_ok, vecs[i].iaok);
      check1("tbl_data_addr_ok", data_bus.addr_ok, vecs[i].daok);
      check1("tbl_inst_data_ok", inst_bus.data_ok, vecs[i].idok);
      check1("tbl_data_data_ok", data_bus.data_ok, vecs[i].ddok);
      if (vecs[i].idok) check32("tbl_inst_rdata", inst_bus.rdata, 32'ha500_0000 + 32'(i));
      if (vecs[i].ddok) check32("tbl_data_rdata", data_bus.rdata, 32'ha500_0000 + 32'(i));
      check1("tbl_arb_err", arb_err, vecs[i].err);
      tick();
    end

    // Tie break: DATA first, then INST; responses return in grant order
    do_reset();
    n = RR_EN ? 4 : 2;
    for (int i = 0; i < n; i++) begin
      drive(1'b1, 1'b1, (i == 0) || RR_EN, 1'b1, 1'b0);
      check1("tie_mem_req", mem_bus.req, 1'b1);
      check1("tie_data_addr_ok", data_bus.addr_ok, (i % 2 == 0));
      check1("tie_inst_addr_ok", inst_bus.addr_ok, (i % 2 == 1));
      tick();
    end
    for (int i = 0; i < n; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      check1("tie_data_data_ok", data_bus.data_ok, (i % 2 == 0));
      check1("tie_inst_data_ok", inst_bus.data_ok, (i % 2 == 1));
      tick();
    end

    // Grant lock: INST held for 3 cycles while data_req rises
    do_reset();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check1("hold_mem_req", mem_bus.req, 1'b1);
    check32("hold_addr0", mem_bus.addr, 32'h0000_1000);
    check1("hold_inst_addr_ok0", inst_bus.addr_ok, 1'b0);
    tick();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      check32("hold_addr", mem_bus.addr, 32'h0000_1000);
      check1("hold_data_addr_ok", data_bus.addr_ok, 1'b0);
      tick();
    end
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    check32("hold_accept_addr", mem_bus.addr, 32'h0000_1000);
    check1("hold_inst_addr_ok", inst_bus.addr_ok, 1'b1);
    check1("hold_data_addr_ok_acc", data_bus.addr_ok, 1'b0);
    tick();
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    check32("hold_next_addr", mem_bus.addr, 32'h0000_2000);
    check1("hold_next_data_addr_ok", data_bus.addr_ok, 1'b1);
    tick();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    check1("hold_resp0_inst", inst_bus.data_ok, 1'b1);
    check1("hold_resp0_data", data_bus.data_ok, 1'b0);
    tick();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    check1("hold_resp1_data", data_bus.data_ok, 1'b1);
    tick();

    // FIFO full: no request while full; a pop re-enables request next cycle
    do_reset();
    for (int k = 0; k < D; k++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      check1("full_fill_addr_ok", inst_bus.addr_ok, 1'b1);
      tick();
    end
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    check1("full_mem_req", mem_bus.req, 1'b0);
    check1("full_inst_addr_ok", inst_bus.addr_ok, 1'b0);
    tick();
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    check1("full_pop_mem_req", mem_bus.req, 1'b0);
    check1("full_pop_data_ok", inst_bus.data_ok, 1'b1);
    tick();
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    check1("full_resume_mem_req", mem_bus.req, 1'b1);
    check1("full_resume_addr_ok", inst_bus.addr_ok, 1'b1);
    tick();
    check32("full_count", 32'(dbg_count), 32'd4);

    // Reset mid-transaction; a late response afterwards is an error
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check1("rst_mem_req", mem_bus.req, 1'b0);
    tick();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    check1("late_inst_data_ok", inst_bus.data_ok, 1'b0);
    check1("late_data_data_ok", data_bus.data_ok, 1'b0);
    check1("late_err_before", arb_err, 1'b0);
    tick();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check1("late_err_after", arb_err, 1'b1);
    check32("late_count", 32'(dbg_count), 32'd0);
    tick();

    // Randomized run against the reference model
    do_reset();
    model_clear();
    ipend = 1'b0;
    dpend = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      rst_now = ($urandom_range(0, 149) == 0);
      if (!ipend) begin
        inst_bus.req   = 1'($urandom_range(0, 1));
        inst_bus.wr    = 1'($urandom_range(0, 1));
        inst_bus.size  = 2'($urandom_range(0, 2));
        inst_bus.addr  = $urandom;
        inst_bus.wstrb = 4'($urandom_range(0, 15));
        inst_bus.wdata = $urandom;
      end
      if (!dpend) begin
        data_bus.req   = 1'($urandom_range(0, 1));
        data_bus.wr    = 1'($urandom_range(0, 1));
        data_bus.size  = 2'($urandom_range(0, 2));
        data_bus.addr  = $urandom;
        data_bus.wstrb = 4'($urandom_range(0, 15));
        data_bus.wdata = $urandom;
      end
      resetn          = !rst_now;
      mem_bus.addr_ok = ($urandom_range(0, 3) != 0);
      if (exp_q.size() > 0) mem_bus.data_ok = 1'($urandom_range(0, 1));
      else                  mem_bus.data_ok = ($urandom_range(0, 299) == 0);
      mem_bus.rdata = $urandom;
      #1;

      // Expected behaviour for this cycle
      m_mreq = 1'b0;
      m_g    = INST;
      if (!rst_now) begin
        if (m_lock >= 0) begin
          m_mreq = 1'b1;
          m_g    = (m_lock == 1);
        end else if (exp_q.size() < D && (inst_bus.req || data_bus.req)) begin
          m_mreq = 1'b1;
          if (inst_bus.req && data_bus.req) m_g = RR_EN ? m_pref : DATA;
          else                              m_g = data_bus.req;
        end
      end
      m_acc  = m_mreq && mem_bus.addr_ok;
      m_pop  = !rst_now && mem_bus.data_ok && (exp_q.size() > 0);
      m_head = (exp_q.size() > 0) ? exp_q[0] : 1'b0;

      check1("rnd_mem_req", mem_bus.req, m_mreq);
      if (m_mreq) begin
        check32("rnd_mem_addr", mem_bus.addr, m_g ? data_bus.addr : inst_bus.addr);
        check32("rnd_mem_wdata", mem_bus.wdata, m_g ? data_bus.wdata : inst_bus.wdata);
        check32("rnd_mem_ctrl", {25'd0, mem_bus.wr, mem_bus.size, mem_bus.wstrb},
                m_g ? {25'd0, data_bus.wr, data_bus.size, data_bus.wstrb}
                    : {25'd0, inst_bus.wr, inst_bus.size, inst_bus.wstrb});
      end
      check1("rnd_inst_addr_ok", inst_bus.addr_ok, m_acc && (m_g == INST));
      check1("rnd_data_addr_ok", data_bus.addr_ok, m_acc && (m_g == DATA));
      check1("rnd_inst_data_ok", inst_bus.data_ok, m_pop && (m_head == INST));
      check1("rnd_data_data_ok", data_bus.data_ok, m_pop && (m_head == DATA));
      if (m_pop) begin
        check32("rnd_rdata", m_head ? data_bus.rdata : inst_bus.rdata, mem_bus.rdata);
      end
      check1("rnd_arb_err", arb_err, m_err);

      // Advance the model
      if (rst_now) begin
        model_clear();
        ipend = 1'b0;
        dpend = 1'b0;
      end else begin
        if (mem_bus.data_ok && exp_q.size() == 0) m_err = 1'b1;
        if (m_pop) void'(exp_q.pop_front());
        if (m_acc) begin
          exp_q.push_back(m_g);
          m_pref = ~m_g;
        end
        m_lock = (m_mreq && !m_acc) ? int'(m_g) : -1;
        ipend  = inst_bus.req && !(m_acc && m_g == INST);
        dpend  = data_bus.req && !(m_acc && m_g == DATA);
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
